// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single data-cache request port between the
// pipeline load/store stage (requester 0) and the secondary memory client
// (requester 1). One transaction is outstanding at a time.
//
// Handshake: a requester holds rqN_valid with stable fields; rqN_ready is a
// combinational one-cycle grant taken only in IDLE. Toward the cache, valid is
// held with stable fields until addr_ready; completion is data_valid or any
// exception bit. The response is a registered one-cycle rsN_valid pulse to the
// requester that owned the grant, with all rsN buses zero outside the pulse.
//
// dbg_state exposes the FSM: 0 = IDLE, 1 = REQ, 2 = WAIT, 3 = DRAIN.
module dcache_port_arbiter #(
    parameter int         TIMEOUT_CYCLES = 1023,
    parameter logic [6:0] TIMEOUT_EXP    = 7'b1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        rq0_valid,
    input  logic        rq0_op,
    input  logic [31:0] rq0_addr,
    input  logic [3:0]  rq0_wtype,
    input  logic [31:0] rq0_wdata,
    input  logic        rq0_atom,
    output logic        rq0_ready,
    input  logic        rq1_valid,
    input  logic        rq1_op,
    input  logic [31:0] rq1_addr,
    input  logic [3:0]  rq1_wtype,
    input  logic [31:0] rq1_wdata,
    input  logic        rq1_atom,
    output logic        rq1_ready,
    output logic        rs0_valid,
    output logic [31:0] rs0_data,
    output logic [6:0]  rs0_exp,
    output logic [31:0] rs0_badv,
    output logic        rs1_valid,
    output logic [31:0] rs1_data,
    output logic [6:0]  rs1_exp,
    output logic [31:0] rs1_badv,
    output logic        valid,
    output logic        op,
    output logic [31:0] addr,
    output logic [3:0]  write_type,
    output logic [31:0] w_data_CPU,
    output logic        is_atom,
    input  logic        addr_ready,
    input  logic        data_valid,
    input  logic [31:0] r_data_CPU,
    input  logic [31:0] cache_badv_in,
    input  logic [6:0]  cache_exception,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        grant_any, grant_id, last_id, lat_id;
    logic        cache_done, tmo_hit, done;
    logic [31:0] tmo_cnt;
    logic        lat_op, lat_atom;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wtype;
    logic [1:0]  rsp_v;
    logic [31:0] rsp_data, rsp_badv;
    logic [6:0]  rsp_exp;

    // Round-robin choice: a lone requester wins, otherwise the one not granted last.
    always_comb begin
        grant_any = (state == S_IDLE) && !flush && (rq0_valid || rq1_valid);
        if (rq0_valid && rq1_valid) grant_id = ~last_id;
        else                        grant_id = rq1_valid;
    end

    // The timeout fires on the last allowed wait cycle, so the pulse follows
    // exactly TIMEOUT_CYCLES wait cycles; TIMEOUT_CYCLES == 0 never fires.
    assign cache_done = data_valid || (|cache_exception);
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign done       = cache_done || tmo_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a flush coinciding with completion simply drops the result.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_REQ;
            S_REQ: begin
                if (flush)           state_nxt = S_IDLE;
                else if (addr_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush)     state_nxt = done ? S_IDLE : S_DRAIN;
                else if (done) state_nxt = S_IDLE;
            end
            S_DRAIN: if (done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: grant strobes and the cache request valid.
    always_comb begin
        rq0_ready = 1'b0;
        rq1_ready = 1'b0;
        if (!rst) begin
            rq0_ready = grant_any && !grant_id;
            rq1_ready = grant_any &&  grant_id;
        end
        valid     = (state == S_REQ);
        dbg_state = state;
    end

    // Request latch, arbitration pointer, timeout counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_id    <= 1'b0;
            lat_op    <= 1'b0;
            lat_addr  <= '0;
            lat_wtype <= '0;
            lat_wdata <= '0;
            lat_atom  <= 1'b0;
            last_id   <= 1'b1;
            tmo_cnt   <= '0;
            rsp_v     <= 2'b00;
            rsp_data  <= '0;
            rsp_exp   <= '0;
            rsp_badv  <= '0;
        end else begin
            rsp_v <= 2'b00;
            if (grant_any) begin
                lat_id    <= grant_id;
                lat_op    <= grant_id ? rq1_op    : rq0_op;
                lat_addr  <= grant_id ? rq1_addr  : rq0_addr;
                lat_wtype <= grant_id ? rq1_wtype : rq0_wtype;
                lat_wdata <= grant_id ? rq1_wdata : rq0_wdata;
                lat_atom  <= grant_id ? rq1_atom  : rq0_atom;
                last_id   <= grant_id;
            end
            if ((state == S_WAIT || state == S_DRAIN) && state_nxt == state)
                tmo_cnt <= tmo_cnt + 32'd1;
            else
                tmo_cnt <= '0;
            if (state == S_WAIT && !flush && done) begin
                rsp_v <= lat_id ? 2'b10 : 2'b01;
                if (cache_done) begin
                    rsp_data <= (data_valid && !(|cache_exception)) ? r_data_CPU : 32'd0;
                    rsp_exp  <= cache_exception;
                    rsp_badv <= (|cache_exception) ? cache_badv_in : 32'd0;
                end else begin
                    rsp_data <= 32'd0;
                    rsp_exp  <= TIMEOUT_EXP;
                    rsp_badv <= lat_addr;
                end
            end
        end
    end

    assign op         = lat_op;
    assign addr       = lat_addr;
    assign write_type = lat_wtype;
    assign w_data_CPU = lat_wdata;
    assign is_atom    = lat_atom;

    assign rs0_valid = rsp_v[0];
    assign rs0_data  = rsp_v[0] ? rsp_data : 32'd0;
    assign rs0_exp   = rsp_v[0] ? rsp_exp  : 7'd0;
    assign rs0_badv  = rsp_v[0] ? rsp_badv : 32'd0;
    assign rs1_valid = rsp_v[1];
    assign rs1_data  = rsp_v[1] ? rsp_data : 32'd0;
    assign rs1_exp   = rsp_v[1] ? rsp_exp  : 7'd0;
    assign rs1_badv  = rsp_v[1] ? rsp_badv : 32'd0;

endmodule
